// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sequencer
//  Description : Command sequencer for an external accumulator datapath.
//                Accepts a command, clears the accumulator, drives the
//                operands for a programmed number of cycles and then
//                captures the registered result and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_sequencer #(
   parameter int NB_DATA = 3,
   parameter int NB_ACC  = 6,
   parameter int NB_LEN  = 4
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [1:0]         i_cmd_sel,
   input  logic [NB_DATA-1:0] i_cmd_a,
   input  logic [NB_DATA-1:0] i_cmd_b,
   input  logic [NB_LEN-1:0]  i_cmd_len,
   input  logic               i_abort,
   output logic               o_acc_clr_n,
   output logic [1:0]         o_sel,
   output logic [NB_DATA-1:0] o_data1,
   output logic [NB_DATA-1:0] o_data2,
   input  logic [NB_ACC-1:0]  i_acc_data,
   input  logic               i_acc_ovf,
   output logic [NB_ACC-1:0]  o_result,
   output logic               o_ovf,
   output logic               o_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q,  state_d;
   logic [1:0]         sel_q,    sel_d;
   logic [NB_DATA-1:0] a_q,      a_d;
   logic [NB_DATA-1:0] b_q,      b_d;
   logic [NB_LEN-1:0]  cnt_q,    cnt_d;
   logic               sticky_q, sticky_d;
   logic [NB_ACC-1:0]  result_q, result_d;
   logic               ovf_q,    ovf_d;

   logic               run_w;
   logic               busy_w;

   // State, command latches, run counter and result registers
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy_w = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_WAIT);

   // Next-state logic; the counter doubles as the latched length field
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      result_d = result_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               sel_d   = i_cmd_sel;
               a_d     = i_cmd_a;
               b_d     = i_cmd_b;
               cnt_d   = i_cmd_len;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            sticky_d = 1'b0;
            state_d  = (cnt_q != '0) ? S_RUN : S_WAIT;
         end
         S_RUN: begin
            if (i_acc_ovf) sticky_d = 1'b1;
            cnt_d = cnt_q - NB_LEN'(1);
            if (cnt_q == NB_LEN'(1)) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_acc_ovf) sticky_d = 1'b1;
            result_d = i_acc_data;
            ovf_d    = sticky_q | i_acc_ovf;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything in the busy states and discards the capture
      if (i_abort && busy_w) begin
         state_d  = S_IDLE;
         result_d = result_q;
         ovf_d    = ovf_q;
      end
   end

   assign run_w       = (state_q == S_RUN);
   assign o_cmd_ready = (state_q == S_IDLE);
   // Reset also holds the datapath in clear so it comes up empty
   assign o_acc_clr_n = ~i_rst & (state_q != S_CLEAR);
   assign o_sel       = run_w ? sel_q : 2'b00;
   assign o_data1     = run_w ? a_q   : '0;
   assign o_data2     = run_w ? b_q   : '0;
   assign o_result    = result_q;
   assign o_ovf       = ovf_q;
   assign o_done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_sequencer
//  Description : Self-checking bench for acc_sequencer with a behavioural
//                accumulator datapath and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sequencer;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_cmd_valid;
   logic       o_cmd_ready;
   logic [1:0] i_cmd_sel;
   logic [2:0] i_cmd_a;
   logic [2:0] i_cmd_b;
   logic [3:0] i_cmd_len;
   logic       i_abort;
   logic       o_acc_clr_n;
   logic [1:0] o_sel;
   logic [2:0] o_data1;
   logic [2:0] o_data2;
   logic [5:0] i_acc_data;
   logic       i_acc_ovf;
   logic [5:0] o_result;
   logic       o_ovf;
   logic       o_done;

   typedef struct {
      logic [1:0] sel;
      logic [2:0] a;
      logic [2:0] b;
      logic [3:0] len;
      logic [5:0] res;
      logic       ovf;
   } cmd_t;

   cmd_t       vec [8];
   logic [6:0] sb [$];
   logic [6:0] sb_head;
   int         total = 0;
   int         bad   = 0;

   acc_sequencer #(.NB_DATA(3), .NB_ACC(6), .NB_LEN(4)) dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_sel   (i_cmd_sel),
      .i_cmd_a     (i_cmd_a),
      .i_cmd_b     (i_cmd_b),
      .i_cmd_len   (i_cmd_len),
      .i_abort     (i_abort),
      .o_acc_clr_n (o_acc_clr_n),
      .o_sel       (o_sel),
      .o_data1     (o_data1),
      .o_data2     (o_data2),
      .i_acc_data  (i_acc_data),
      .i_acc_ovf   (i_acc_ovf),
      .o_result    (o_result),
      .o_ovf       (o_ovf),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   // Datapath model: sel=01 adds data1, sel=10 adds data2, otherwise hold;
   // ovf is the registered carry of the most recent add
   always @(posedge clk or negedge o_acc_clr_n) begin
      if (!o_acc_clr_n) begin
         i_acc_data <= 6'd0;
         i_acc_ovf  <= 1'b0;
      end else begin
         case (o_sel)
            2'b01:   {i_acc_ovf, i_acc_data} <= {1'b0, i_acc_data} + {4'd0, o_data1};
            2'b10:   {i_acc_ovf, i_acc_data} <= {1'b0, i_acc_data} + {4'd0, o_data2};
            default: i_acc_ovf <= 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [10:0] obs();
      return {o_cmd_ready, o_acc_clr_n, o_sel, o_data1, o_data2, o_done};
   endfunction

   function automatic logic [10:0] exp_vec(input logic rdy, input logic clrn,
                                           input logic [1:0] s, input logic [2:0] d1,
                                           input logic [2:0] d2, input logic dn);
      return {rdy, clrn, s, d1, d2, dn};
   endfunction

   // Completion monitor: every o_done must match the oldest expected result
   always @(negedge clk) begin
      if (i_rst === 1'b0 && o_done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(o_done), 32'd0);
         end else begin
            sb_head = sb.pop_front();
            chk("done_result", 32'({o_ovf, o_result}), 32'(sb_head));
         end
      end
   end

   task automatic set_fields(input cmd_t c);
      i_cmd_sel = c.sel;
      i_cmd_a   = c.a;
      i_cmd_b   = c.b;
      i_cmd_len = c.len;
   endtask

   // Wait for IDLE, present the command, return just after the accepting edge
   task automatic issue(input cmd_t c, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (o_cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(o_cmd_ready), 32'd1);
      set_fields(c);
      i_cmd_valid = 1'b1;
      if (push) sb.push_back({c.ovf, c.res});
      @(posedge clk);
   endtask

   // Check every cycle from CLEAR through DONE against the latency table
   task automatic follow(input cmd_t c, input bit chain, input cmd_t nxt);
      for (int cyc = 1; cyc <= int'(c.len) + 3; cyc++) begin
         logic run;
         @(negedge clk);
         run = (cyc >= 2) && (cyc <= int'(c.len) + 1);
         chk($sformatf("len%0d_cyc%0d", c.len, cyc), 32'(obs()),
             32'(exp_vec(1'b0, cyc != 1, run ? c.sel : 2'b00, run ? c.a : 3'd0,
                         run ? c.b : 3'd0, cyc == int'(c.len) + 3)));
         if (cyc == 1) begin
            if (chain) begin
               set_fields(nxt);
               sb.push_back({nxt.ovf, nxt.res});
            end else begin
               i_cmd_valid = 1'b0;
            end
         end
      end
   endtask

   initial begin
      cmd_t ca, cn, cr, cf, c1, c2;
      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      i_abort     = 1'b0;
      i_cmd_sel   = 2'b00;
      i_cmd_a     = 3'd0;
      i_cmd_b     = 3'd0;
      i_cmd_len   = 4'd0;

      //          sel    a     b     len    result ovf
      vec[0] = '{2'b01, 3'd3, 3'd2, 4'd4,  6'd12, 1'b0};
      vec[1] = '{2'b01, 3'd7, 3'd0, 4'd10, 6'd6,  1'b1};
      vec[2] = '{2'b01, 3'd5, 3'd1, 4'd0,  6'd0,  1'b0};
      vec[3] = '{2'b10, 3'd1, 3'd5, 4'd15, 6'd11, 1'b1};
      vec[4] = '{2'b01, 3'd7, 3'd7, 4'd9,  6'd63, 1'b0};
      vec[5] = '{2'b00, 3'd7, 3'd7, 4'd3,  6'd0,  1'b0};
      vec[6] = '{2'b01, 3'd1, 3'd0, 4'd1,  6'd1,  1'b0};
      vec[7] = '{2'b10, 3'd0, 3'd3, 4'd5,  6'd15, 1'b0};

      #3;
      chk("reset_outputs", 32'(obs()), 32'(exp_vec(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0)));
      chk("reset_result", 32'({o_ovf, o_result}), 32'd0);
      #9 i_rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 32'(obs()), 32'(exp_vec(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0)));

      for (int i = 0; i < 8; i++) begin
         issue(vec[i], 1'b1);
         follow(vec[i], 1'b0, vec[i]);
         @(negedge clk);
         chk($sformatf("idle_after_v%0d", i), 32'(obs()),
             32'(exp_vec(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0)));
         chk($sformatf("hold_v%0d", i), 32'({o_ovf, o_result}), 32'({vec[i].ovf, vec[i].res}));
      end

      // Abort in the third RUN cycle with a new command already pending
      ca = '{2'b01, 3'd2, 3'd0, 4'd6, 6'd0, 1'b0};
      cn = '{2'b01, 3'd4, 3'd0, 4'd2, 6'd8, 1'b0};
      issue(ca, 1'b0);
      for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
      chk("abort_run3", 32'(obs()), 32'(exp_vec(1'b0, 1'b1, 2'b01, 3'd2, 3'd0, 1'b0)));
      i_abort = 1'b1;
      set_fields(cn);
      sb.push_back({cn.ovf, cn.res});
      @(negedge clk);
      chk("abort_idle", 32'(obs()), 32'(exp_vec(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0)));
      chk("abort_hold", 32'({o_ovf, o_result}), 32'({1'b0, 6'd15}));
      i_abort = 1'b0;
      @(posedge clk);
      follow(cn, 1'b0, cn);
      @(negedge clk);
      chk("after_abort_hold", 32'({o_ovf, o_result}), 32'({1'b0, 6'd8}));

      // Asynchronous reset pulse in the middle of RUN
      cr = '{2'b01, 3'd3, 3'd0, 4'd8, 6'd0, 1'b0};
      cf = '{2'b01, 3'd6, 3'd1, 4'd3, 6'd18, 1'b0};
      issue(cr, 1'b0);
      i_cmd_valid = 1'b0;
      for (int cyc = 1; cyc <= 3; cyc++) @(negedge clk);
      #2 i_rst = 1'b1;
      #1;
      chk("midrun_reset_outputs", 32'(obs()), 32'(exp_vec(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 1'b0)));
      chk("midrun_reset_result", 32'({o_ovf, o_result}), 32'd0);
      #5 i_rst = 1'b0;
      @(negedge clk);
      chk("idle_after_midrun_reset", 32'(obs()), 32'(exp_vec(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0)));
      issue(cf, 1'b1);
      follow(cf, 1'b0, cf);
      @(negedge clk);
      chk("after_reset_hold", 32'({o_ovf, o_result}), 32'({1'b0, 6'd18}));

      // Back-to-back commands with valid held high
      c1 = '{2'b01, 3'd1, 3'd0, 4'd2, 6'd2, 1'b0};
      c2 = '{2'b01, 3'd2, 3'd0, 4'd3, 6'd6, 1'b0};
      issue(c1, 1'b1);
      follow(c1, 1'b1, c2);
      @(negedge clk);
      chk("b2b_idle", 32'(obs()), 32'(exp_vec(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0)));
      @(posedge clk);
      follow(c2, 1'b0, c2);
      @(negedge clk);
      chk("b2b_hold", 32'({o_ovf, o_result}), 32'({1'b0, 6'd6}));

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter NB_DATA, default 3: operand width driven to the accumulator datapath.
REQ-002 Parameter NB_ACC, default 6: accumulator result width.
REQ-003 Parameter NB_LEN, default 4: command length field width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, exposed as the following ports.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_cmd_valid  input  1  command request.
REQ-008 o_cmd_ready  output  1  command accepted on a clk edge when i_cmd_valid=1 and o_cmd_ready=1.
REQ-009 i_cmd_sel  input  2  mux select applied during RUN.
REQ-010 i_cmd_a, i_cmd_b  input  NB_DATA each  operands applied during RUN.
REQ-011 i_cmd_len  input  NB_LEN  number of accumulate cycles, 0..15.
REQ-012 i_abort  input  1  cancel the in-flight command.
REQ-013 o_acc_clr_n  output  1  drives the datapath active-low reset; 0 clears the accumulator.
REQ-014 o_sel  output  2; o_data1, o_data2  output  NB_DATA each  datapath drive.
REQ-015 i_acc_data  input  NB_ACC; i_acc_ovf  input  1  registered datapath result and overflow.
REQ-016 o_result  output  NB_ACC; o_ovf  output  1; o_done  output  1  completion report.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RUN, WAIT and DONE.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE; on acceptance the block latches sel, a, b and len, then enters CLEAR.
REQ-019 CLEAR SHALL last 1 cycle with o_acc_clr_n=0 and the sticky overflow cleared; next state is RUN if len>0, else WAIT.
REQ-020 RUN SHALL drive o_sel, o_data1 and o_data2 from the latched command for exactly len consecutive cycles, counted by a down-counter loaded with len; RUN exits to WAIT when the counter equals 1.
REQ-021 Outside RUN, o_data1, o_data2 and o_sel SHALL be 0, so the datapath adds nothing and the accumulator holds.
REQ-022 WAIT SHALL last 1 cycle; on its closing edge o_result <= i_acc_data and o_ovf <= sticky | i_acc_ovf.
REQ-023 The sticky overflow SHALL be set by i_acc_ovf=1 sampled in any RUN or WAIT cycle.
REQ-024 DONE SHALL last 1 cycle with o_done=1, then the FSM returns to IDLE; o_done is 0 in every other state.
REQ-025 Latency: with acceptance at edge 0, CLEAR occupies cycle 1, RUN cycles 2..len+1, WAIT cycle len+2 and DONE cycle len+3.
REQ-026 For len=0 the sequence SHALL be CLEAR, WAIT, DONE, giving o_result=0 and o_ovf=0 for a correctly cleared datapath.
REQ-027 o_result and o_ovf SHALL hold their values until the next WAIT-closing edge.
REQ-028 i_abort=1 in CLEAR, RUN or WAIT SHALL force IDLE on the next edge, with no o_done and o_result/o_ovf unchanged; i_abort is ignored in IDLE and DONE.
REQ-029 If i_abort and i_cmd_valid are both 1, abort SHALL take priority; the command is not accepted in that cycle and only becomes eligible once IDLE is reached.
REQ-030 o_acc_clr_n SHALL be 1 in IDLE, RUN, WAIT and DONE.

Reset
REQ-031 While i_rst=1, asynchronously: state=IDLE, o_cmd_ready=1, o_acc_clr_n=0, o_sel/o_data1/o_data2=0, o_result=0, o_ovf=0, o_done=0, counter and latches=0.
REQ-032 Reset asserted mid-command SHALL discard the command, with no o_done; after release the block idles with o_acc_clr_n=1.

Verification
Bench uses a behavioural datapath model in which sel=01 adds data1 to a 6-bit accumulator with a 1-cycle registered output.
REQ-033 Accept sel=01, a=3, b=2, len=4 -> clr_n=0 in cycle 1; o_sel=01, o_data1=3, o_data2=2 in cycles 2..5 only; o_done=1 in cycle 7; o_result=12; o_ovf=0.
REQ-034 Accept sel=01, a=7, len=10 -> the model overflows past 63; o_ovf=1 at DONE and o_result=model value (70 mod 64 = 6).
REQ-035 Accept len=0 -> o_done in cycle 3, o_result=0, no RUN cycle, o_data1 stays 0 throughout.
REQ-036 i_abort=1 in the third RUN cycle with i_cmd_valid=1 -> IDLE next edge, no o_done, o_result keeps its prior value; the pending command is accepted the following cycle.
REQ-037 i_rst pulsed mid-RUN, asynchronously between edges -> outputs reach reset values immediately, o_acc_clr_n=0 during reset, and a fresh command completes normally afterwards.
REQ-038 Back-to-back commands with i_cmd_valid held high -> o_cmd_ready=0 from acceptance through DONE; the second command is accepted in the IDLE cycle after DONE.
